// File: rtl/pong_match_ctrl.sv
// ============================================================================
// Module   : pong_match_ctrl
// Brief    : Pong match flow and scoring controller (serve, play, point, pause, over).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pong_match_ctrl #(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 30,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               pause,
    input  logic               mode_wb2,
    input  logic               score1_evt,
    input  logic               score2_evt,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               ball_en,
    output logic               ball_rst,
    output logic               serve_dir,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_POINT  = 3'd3,
        S_PAUSED = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    localparam logic [SCORE_W-1:0] C_SCORE_MAX = '1;
    localparam logic [SCORE_W:0]   C_WIN       = (SCORE_W+1)'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   C_SERVE     = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0]   C_POINT     = CNT_W'(POINT_TICKS);

    state_t             r_state;
    state_t             r_ret_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_prev1;
    logic               r_prev2;
    logic               r_mode;

    logic               w_rise1;
    logic               w_rise2;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [SCORE_W-1:0] w_new1;
    logic [SCORE_W-1:0] w_new2;
    logic               w_win1;
    logic               w_win2;

    // Win uses the post-increment score; a pinned (saturated) leader also wins.
    function automatic logic win_test(input logic [SCORE_W-1:0] scorer,
                                      input logic [SCORE_W-1:0] other,
                                      input logic               wb2);
        logic [SCORE_W:0] n;
        logic [SCORE_W:0] o;
        n = {1'b0, scorer};
        o = {1'b0, other};
        win_test = ((n >= C_WIN) && (!wb2 || (n >= o + (SCORE_W+1)'(2))))
                 || ((scorer == C_SCORE_MAX) && (n > o));
    endfunction

    always_comb begin
        w_rise1   = score1_evt & ~r_prev1;
        w_rise2   = score2_evt & ~r_prev2;
        w_cnt_inc = r_cnt + CNT_W'(1);
        w_new1    = (score1 == C_SCORE_MAX) ? score1 : score1 + SCORE_W'(1);
        w_new2    = (score2 == C_SCORE_MAX) ? score2 : score2 + SCORE_W'(1);
        w_win1    = win_test(w_new1, score2, r_mode);
        w_win2    = win_test(w_new2, score1, r_mode);
    end

    assign state_o   = r_state;
    assign ball_en   = (r_state == S_PLAY);
    assign ball_rst  = (r_state != S_PLAY) && (r_state != S_PAUSED);
    assign game_over = (r_state == S_OVER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ret_state <= S_IDLE;
            r_cnt       <= '0;
            r_prev1     <= 1'b0;
            r_prev2     <= 1'b0;
            r_mode      <= 1'b0;
            score1      <= '0;
            score2      <= '0;
            serve_dir   <= 1'b0;
            winner      <= 2'b00;
        end else begin
            // History tracks in every state so a held level never scores later.
            r_prev1 <= score1_evt;
            r_prev2 <= score2_evt;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_state   <= S_SERVE;
                        score1    <= '0;
                        score2    <= '0;
                        r_cnt     <= '0;
                        r_mode    <= mode_wb2;
                        serve_dir <= 1'b0;
                        winner    <= 2'b00;
                    end
                end
                S_SERVE: begin
                    if (pause) begin
                        r_ret_state <= S_SERVE;
                        r_state     <= S_PAUSED;
                    end else if (tick) begin
                        if (w_cnt_inc == C_SERVE) begin
                            r_state <= S_PLAY;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_POINT: begin
                    if (pause) begin
                        r_ret_state <= S_POINT;
                        r_state     <= S_PAUSED;
                    end else if (tick) begin
                        if (w_cnt_inc == C_POINT) begin
                            r_state <= S_SERVE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_PLAY: begin
                    if (pause) begin
                        r_ret_state <= S_PLAY;
                        r_state     <= S_PAUSED;
                    end else if (w_rise1 && w_rise2) begin
                        r_state <= S_POINT;
                        r_cnt   <= '0;
                    end else if (w_rise1) begin
                        score1    <= w_new1;
                        serve_dir <= 1'b1;
                        r_cnt     <= '0;
                        if (w_win1) begin
                            r_state <= S_OVER;
                            winner  <= 2'b01;
                        end else begin
                            r_state <= S_POINT;
                        end
                    end else if (w_rise2) begin
                        score2    <= w_new2;
                        serve_dir <= 1'b0;
                        r_cnt     <= '0;
                        if (w_win2) begin
                            r_state <= S_OVER;
                            winner  <= 2'b10;
                        end else begin
                            r_state <= S_POINT;
                        end
                    end
                end
                S_PAUSED: begin
                    if (pause) begin
                        r_state <= r_ret_state;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
// ============================================================================
// Module   : tb_pong_match_ctrl
// Brief    : Scoreboard bench for pong_match_ctrl with directed match scenarios.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       mode_wb2 = 1'b0;
    logic       score1_evt = 1'b0;
    logic       score2_evt = 1'b0;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       ball_en;
    logic       ball_rst;
    logic       serve_dir;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] state_o;

    pong_match_ctrl #(
        .SCORE_W     (4),
        .WIN_SCORE   (3),
        .SERVE_TICKS (3),
        .POINT_TICKS (2),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .pause      (pause),
        .mode_wb2   (mode_wb2),
        .score1_evt (score1_evt),
        .score2_evt (score2_evt),
        .score1     (score1),
        .score2     (score2),
        .ball_en    (ball_en),
        .ball_rst   (ball_rst),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       en;
        logic       br;
        logic       dir;
        logic       go;
        logic [1:0] win;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Monitor: compares each queued expectation against the outputs at the next falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({state_o, score1, score2, ball_en, ball_rst, serve_dir, game_over, winner} !==
                {mon_e.st, mon_e.s1, mon_e.s2, mon_e.en, mon_e.br, mon_e.dir, mon_e.go, mon_e.win}) begin
                errors++;
                $display("FAIL %s: got st=%0d s=%0d-%0d en=%b brst=%b dir=%b go=%b win=%b, want st=%0d s=%0d-%0d en=%b brst=%b dir=%b go=%b win=%b",
                         mon_e.name, state_o, score1, score2, ball_en, ball_rst, serve_dir, game_over, winner,
                         mon_e.st, mon_e.s1, mon_e.s2, mon_e.en, mon_e.br, mon_e.dir, mon_e.go, mon_e.win);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic chk(input string nm, input logic [2:0] st, input logic [3:0] s1,
                       input logic [3:0] s2, input logic en, input logic br, input logic dir,
                       input logic go, input logic [1:0] win);
        exp_t e;
        int   k;
        e.name = nm; e.st = st; e.s1 = s1; e.s2 = s2;
        e.en = en; e.br = br; e.dir = dir; e.go = go; e.win = win;
        sb.push_back(e);
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: monitor did not consume expectation, pending=%0d want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    int pw[10] = '{1, 2, 1, 2, 1, 2, 2, 1, 2, 2};
    int e1[10] = '{1, 1, 2, 2, 3, 3, 3, 4, 4, 4};
    int e2[10] = '{0, 1, 1, 2, 2, 3, 4, 4, 5, 6};

    initial begin
        repeat (3) step();
        reset = 1'b1;
        chk("reset", 3'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);

        // Serve countdown into play
        start = 1'b1; step(); start = 1'b0;
        chk("serve_entry", 3'd1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        ticks(2);
        chk("serve_hold", 3'd1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        tick = 1'b1; step(); tick = 1'b0;
        chk("play_entry", 3'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

        // Straight win for P1
        for (int i = 1; i <= 3; i++) begin
            score1_evt = 1'b1; step(); score1_evt = 1'b0;
            if (i < 3) begin
                chk("p1_point", 3'd3, 4'(i), 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
                ticks(2);
                chk("point_to_serve", 3'd1, 4'(i), 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
                ticks(3);
            end else begin
                chk("p1_win", 3'd5, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
            end
        end
        score1_evt = 1'b1; step(); score1_evt = 1'b0;
        chk("over_hold", 3'd5, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01);

        // Win-by-two match from OVER; mode change after start must not matter
        mode_wb2 = 1'b1; start = 1'b1; step(); start = 1'b0; mode_wb2 = 1'b0;
        chk("wb2_start", 3'd1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        ticks(3);
        for (int i = 0; i < 10; i++) begin
            if (pw[i] == 1) score1_evt = 1'b1;
            else            score2_evt = 1'b1;
            step();
            score1_evt = 1'b0;
            score2_evt = 1'b0;
            if (i < 9) begin
                chk("wb2_point", 3'd3, 4'(e1[i]), 4'(e2[i]), 1'b0, 1'b1, (pw[i] == 1), 1'b0, 2'b00);
                ticks(2);
                ticks(3);
            end else begin
                chk("wb2_win", 3'd5, 4'd4, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
            end
        end

        // Pause freezes play
        start = 1'b1; step(); start = 1'b0;
        ticks(3);
        chk("restart_play", 3'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        pause = 1'b1; step(); pause = 1'b0;
        chk("paused", 3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        score1_evt = 1'b1; step(); score1_evt = 1'b0;
        ticks(3);
        chk("paused_hold", 3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        pause = 1'b1; step(); pause = 1'b0;
        chk("resume", 3'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

        // Simultaneous rises, then async reset mid-POINT
        score1_evt = 1'b1; step(); score1_evt = 1'b0;
        chk("p1_pt", 3'd3, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        ticks(2);
        ticks(3);
        chk("replay", 3'd2, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        score1_evt = 1'b1; score2_evt = 1'b1; step();
        score1_evt = 1'b0; score2_evt = 1'b0;
        chk("double_rise", 3'd3, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick = 1'b1; step(); tick = 1'b0;
        reset = 1'b0;
        chk("async_rst", 3'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        step();
        reset = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
